ccd_uart_frame_rx: RTL

Receive-side frame unpacker for the CCD UART link. It collects 128 payload bytes from the UART receiver into an internal frame buffer and checks the 0xFF terminator. Only a complete, correctly terminated frame is drained into the downstream FIFO, followed by a frame-done strobe. It sits between the UART RX core (byte + done pulse) and the host-side FIFO, and is the counterpart of the CCD transmit path, which sends 128 bytes followed by 0xFF.

---
 rtl/ccd_uart_frame_rx.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ccd_uart_frame_rx.sv
// Receive-side frame unpacker for the CCD UART link: buffers FRAME_LEN payload bytes,
// checks the terminator, then drains the good frame into the host FIFO.
module ccd_uart_frame_rx #(
  parameter int         FRAME_LEN  = 128,
  parameter logic [7:0] TERM_BYTE  = 8'hFF,
  parameter int         GAP_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_done_sig,
  input  logic [7:0] rx_data,
  input  logic       fifo_full,
  output logic       wrreq,
  output logic [7:0] wrdata,
  output logic       frame_done,
  output logic       frame_err,
  output logic       ovf_err,
  output logic [7:0] byte_cnt
);

  localparam int          AW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [7:0]  LAST_IDX = 8'(FRAME_LEN - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RECV,
    S_TERM,
    S_DRAIN,
    S_DONE,
    S_RESYNC
  } state_t;

  state_t      r_state;
  logic [7:0]  r_byte_cnt;
  logic [7:0]  r_rd_ptr;
  logic [15:0] r_gap_cnt;
  logic        r_frame_done;
  logic        r_frame_err;
  logic        r_ovf_err;
  logic [7:0]  r_buf [0:FRAME_LEN-1];

  logic w_timer_on;
  logic w_timeout;

  // The inter-byte timer only runs once a frame has started and until the terminator.
  assign w_timer_on = ((r_state == S_RECV) && (r_byte_cnt != 8'd0)) || (r_state == S_TERM);
  assign w_timeout  = w_timer_on && !rx_done_sig && (r_gap_cnt == GAP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_RECV;
      r_byte_cnt   <= 8'd0;
      r_rd_ptr     <= 8'd0;
      r_gap_cnt    <= 16'd0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_ovf_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; later lines override these pulse defaults.
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_ovf_err    <= 1'b0;

      if (rx_done_sig || !w_timer_on || w_timeout) begin
        r_gap_cnt <= 16'd0;
      end else begin
        r_gap_cnt <= r_gap_cnt + 16'd1;
      end

      case (r_state)
        S_RECV: begin
          if (rx_done_sig) begin
            r_byte_cnt <= r_byte_cnt + 8'd1;
            if (r_byte_cnt == LAST_IDX) begin
              r_state <= S_TERM;
            end
          end else if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_byte_cnt  <= 8'd0;
          end
        end

        S_TERM: begin
          if (rx_done_sig) begin
            if (rx_data == TERM_BYTE) begin
              r_state  <= S_DRAIN;
              r_rd_ptr <= 8'd0;
            end else begin
              r_frame_err <= 1'b1;
              r_byte_cnt  <= 8'd0;
              r_state     <= S_RESYNC;
            end
          end else if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_byte_cnt  <= 8'd0;
            r_state     <= S_RECV;
          end
        end

        S_DRAIN: begin
          if (rx_done_sig) begin
            r_ovf_err <= 1'b1;
          end
          if (!fifo_full) begin
            r_rd_ptr <= r_rd_ptr + 8'd1;
            if (r_rd_ptr == LAST_IDX) begin
              r_state      <= S_DONE;
              r_frame_done <= 1'b1;
            end
          end
        end

        S_DONE: begin
          r_byte_cnt <= 8'd0;
          r_state    <= S_RECV;
        end

        S_RESYNC: begin
          if (rx_done_sig && (rx_data == TERM_BYTE)) begin
            r_byte_cnt <= 8'd0;
            r_state    <= S_RECV;
          end
        end

        default: r_state <= S_RECV;
      endcase
    end
  end

  // NOTE: the frame buffer has no reset; it is always written before it is read.
  always_ff @(posedge clk) begin
    if ((r_state == S_RECV) && rx_done_sig) begin
      r_buf[r_byte_cnt[AW-1:0]] <= rx_data;
    end
  end

  assign wrreq      = (r_state == S_DRAIN) && !fifo_full;
  assign wrdata     = r_buf[r_rd_ptr[AW-1:0]];
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign ovf_err    = r_ovf_err;
  assign byte_cnt   = r_byte_cnt;

endmodule
